// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall/bubble, taken-branch squash, memory-wait
// freeze with timeout, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int FORWARDING  = 1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_src1_valid,
  input  logic             id_src2_valid,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             hazard_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             freeze_all,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mx1, mx2, mm1, mm2;
  logic              raw;
  logic              mem_pend;

  // wb_en gates every match so a reset dest of 4'hF never matches by itself
  assign mx1 = id_src1_valid & exe_wb_en & (id_src1 == exe_dest);
  assign mx2 = id_src2_valid & exe_wb_en & (id_src2 == exe_dest);
  assign mm1 = id_src1_valid & mem_wb_en & (id_src1 == mem_dest);
  assign mm2 = id_src2_valid & mem_wb_en & (id_src2 == mem_dest);

  assign raw = (FORWARDING != 0) ? (exe_mem_r_en & (mx1 | mx2))
                                 : (mx1 | mx2 | mm1 | mm2);

  assign mem_pend    = mem_req & ~mem_ready;
  assign freeze_all  = rst & ((state == ERR) | mem_pend);
  assign mem_timeout = rst & (state == ERR);

  always_comb begin
    hazard_stall = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    if (rst && !freeze_all) begin
      if (branch_taken) begin
        if_flush = 1'b1;
        id_flush = 1'b1;
      end else if (raw) begin
        hazard_stall = 1'b1;
        id_flush     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_pend) begin
            state    <= WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR: state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

  // Counters hold entirely while frozen; otherwise clear beats increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze_all) begin
      if (clr_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (hazard_stall) stall_cnt <= sat_inc(stall_cnt);
        if (if_flush)     flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (forwarding/16-bit/63 and no-forwarding/
// 4-bit/4) share stimulus and are checked against a rule-level reference model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_src1_valid, id_src2_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       branch_taken, mem_req, mem_ready, clr_cnt;

  logic        stall_a, iff_a, idf_a, frz_a, to_a;
  logic [15:0] scnt_a, fcnt_a;
  logic        stall_b, iff_b, idf_b, frz_b, to_b;
  logic [3:0]  scnt_b, fcnt_b;

  hazard_ctrl #(.FORWARDING(1), .CNT_W(16), .MEM_TIMEOUT(63)) dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_valid(id_src1_valid), .id_src2_valid(id_src2_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .hazard_stall(stall_a), .if_flush(iff_a), .id_flush(idf_a),
    .freeze_all(frz_a), .mem_timeout(to_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  hazard_ctrl #(.FORWARDING(0), .CNT_W(4), .MEM_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_valid(id_src1_valid), .id_src2_valid(id_src2_valid),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .hazard_stall(stall_b), .if_flush(iff_b), .id_flush(idf_b),
    .freeze_all(frz_b), .mem_timeout(to_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  int total = 0;
  int bad   = 0;

  logic [15:0] sa, fa;
  logic [3:0]  sb, fb;

  // Expected {freeze, if_flush, id_flush, stall} from the priority rules
  function automatic logic [3:0] exp_outs(input bit fwd);
    bit x1, x2, m1, m2, r;
    x1 = id_src1_valid && exe_wb_en && (id_src1 == exe_dest);
    x2 = id_src2_valid && exe_wb_en && (id_src2 == exe_dest);
    m1 = id_src1_valid && mem_wb_en && (id_src1 == mem_dest);
    m2 = id_src2_valid && mem_wb_en && (id_src2 == mem_dest);
    r  = fwd ? (exe_mem_r_en && (x1 || x2)) : (x1 || x2 || m1 || m2);
    if (mem_req && !mem_ready) return 4'b1000;
    if (branch_taken)          return 4'b0110;
    if (r)                     return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic idle_inputs();
    id_src1 = 4'h0; id_src2 = 4'h0; id_src1_valid = 1'b0; id_src2_valid = 1'b0;
    exe_dest = 4'h0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'h0; mem_wb_en = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic advance();
    logic [3:0] ea, eb;
    ea = exp_outs(1'b1);
    eb = exp_outs(1'b0);
    @(posedge clk);
    if (!ea[3]) begin
      if (clr_cnt) begin sa = '0; fa = '0; end
      else begin
        if (ea[0] && sa != 16'hFFFF) sa = sa + 16'd1;
        if (ea[2] && fa != 16'hFFFF) fa = fa + 16'd1;
      end
    end
    if (!eb[3]) begin
      if (clr_cnt) begin sb = '0; fb = '0; end
      else begin
        if (eb[0] && sb != 4'hF) sb = sb + 4'd1;
        if (eb[2] && fb != 4'hF) fb = fb + 4'd1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sa = '0; fa = '0; sb = '0; fb = '0;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({frz_a, iff_a, idf_a, stall_a, to_a, scnt_a, fcnt_a} !== '0) begin
      bad++; $display("FAIL reset_held_a got=%h want=0", {frz_a, iff_a, idf_a, stall_a, to_a, scnt_a, fcnt_a});
    end
    sa = '0; fa = '0; sb = '0; fb = '0;
    rst = 1'b1;
    advance();
    total++;
    if ({frz_a, iff_a, idf_a, stall_a, to_a, scnt_a, fcnt_a} !== '0 ||
        {frz_b, iff_b, idf_b, stall_b, to_b, scnt_b, fcnt_b} !== '0) begin
      bad++; $display("FAIL reset_release got_a=%h got_b=%h want=0",
        {frz_a, iff_a, idf_a, stall_a, to_a, scnt_a, fcnt_a}, {frz_b, iff_b, idf_b, stall_b, to_b, scnt_b, fcnt_b});
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    #1;
    total++;
    if ({stall_a, idf_a, iff_a} !== 3'b110) begin
      bad++; $display("FAIL load_use got=%b want=110", {stall_a, idf_a, iff_a});
    end
    advance();
    total++;
    if (scnt_a !== 16'd1) begin
      bad++; $display("FAIL load_use_cnt got=%0d want=1", scnt_a);
    end
    exe_mem_r_en = 1'b0;
    #1;
    total++;
    if ({stall_a, idf_a} !== 2'b00 || {stall_b, idf_b} !== 2'b11) begin
      bad++; $display("FAIL no_load got_a=%b got_b=%b want_a=00 want_b=11", {stall_a, idf_a}, {stall_b, idf_b});
    end
    advance();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b0; exe_dest = 4'hF; id_src1 = 4'hF;
    #1;
    total++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0) begin
      bad++; $display("FAIL dest_f_no_wb got_a=%b got_b=%b want=0", stall_a, stall_b);
    end
    advance();
    total++;
    if (scnt_a !== sa || scnt_b !== sb) begin
      bad++; $display("FAIL load_use_cnt2 got_a=%0d got_b=%0d want_a=%0d want_b=%0d", scnt_a, scnt_b, sa, sb);
    end
  endtask

  task automatic test_branch_priority();
    logic [15:0] s0, f0;
    apply_reset();
    id_src1 = 4'd7; id_src1_valid = 1'b1; exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    branch_taken = 1'b1;
    #1;
    s0 = scnt_a; f0 = fcnt_a;
    total++;
    if ({iff_a, idf_a, stall_a} !== 3'b110) begin
      bad++; $display("FAIL branch_prio got=%b want=110", {iff_a, idf_a, stall_a});
    end
    advance();
    total++;
    if (fcnt_a !== f0 + 16'd1 || scnt_a !== s0) begin
      bad++; $display("FAIL branch_cnt got_f=%0d got_s=%0d want_f=%0d want_s=%0d", fcnt_a, scnt_a, f0 + 16'd1, s0);
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    logic [15:0] s0, f0;
    int frz_seen;
    apply_reset();
    s0 = scnt_a; f0 = fcnt_a;
    frz_seen = 0;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      branch_taken = (i == 2);
      #1;
      if (frz_a === 1'b1) frz_seen++;
      total++;
      if (iff_a !== 1'b0 || idf_a !== 1'b0) begin
        bad++; $display("FAIL wait_no_flush cyc=%0d got=%b%b want=00", i, iff_a, idf_a);
      end
      advance();
    end
    branch_taken = 1'b0;
    mem_ready = 1'b1;
    #1;
    total++;
    if (frz_seen != 5 || frz_a !== 1'b0) begin
      bad++; $display("FAIL wait_freeze got_cycles=%0d got_now=%b want=5,0", frz_seen, frz_a);
    end
    advance();
    total++;
    if (scnt_a !== s0 || fcnt_a !== f0) begin
      bad++; $display("FAIL wait_cnt got=%0d,%0d want=%0d,%0d", scnt_a, fcnt_a, s0, f0);
    end
    // one-cycle access after returning to RUN never freezes
    mem_req = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
    #1;
    total++;
    if (frz_a !== 1'b0 || iff_a !== 1'b1 || to_a !== 1'b0) begin
      bad++; $display("FAIL one_cycle_access got=%b%b%b want=010", frz_a, iff_a, to_a);
    end
    advance();
    apply_reset();
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      total++;
      if (frz_b !== 1'b1 || to_b !== 1'b0) begin
        bad++; $display("FAIL timeout_pre cyc=%0d got=%b%b want=10", i, frz_b, to_b);
      end
      advance();
    end
    total++;
    if (to_b !== 1'b1 || to_a !== 1'b0) begin
      bad++; $display("FAIL timeout_set got_b=%b got_a=%b want=1,0", to_b, to_a);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (frz_b !== 1'b1 || to_b !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky got=%b%b want=11", frz_b, to_b);
    end
    mem_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (frz_b !== 1'b0 || to_b !== 1'b0) begin
      bad++; $display("FAIL async_clear got=%b%b want=00", frz_b, to_b);
    end
    apply_reset();
  endtask

  task automatic test_saturation();
    apply_reset();
    id_src1 = 4'd5; id_src1_valid = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1;
    repeat (20) advance();
    total++;
    if (scnt_b !== 4'd15 || scnt_b !== sb) begin
      bad++; $display("FAIL stall_sat got=%0d want=15", scnt_b);
    end
    clr_cnt = 1'b1;
    advance();
    clr_cnt = 1'b0;
    total++;
    if (scnt_b !== 4'd0 || scnt_a !== 16'd0) begin
      bad++; $display("FAIL clr_wins got_b=%0d got_a=%0d want=0", scnt_b, scnt_a);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int left;
    logic [3:0] ea, eb;
    apply_reset();
    left = 0;
    for (int n = 0; n < 400; n++) begin
      id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
      id_src1_valid = 1'($urandom_range(0, 1)); id_src2_valid = 1'($urandom_range(0, 1));
      exe_dest = 4'($urandom_range(0, 3)); exe_wb_en = 1'($urandom_range(0, 1));
      exe_mem_r_en = 1'($urandom_range(0, 1));
      mem_dest = 4'($urandom_range(0, 3)); mem_wb_en = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 5) == 0);
      clr_cnt = ($urandom_range(0, 24) == 0);
      if (left == 0 && $urandom_range(0, 4) == 0) left = $urandom_range(1, 5);
      if (left > 0) begin
        mem_req = 1'b1; mem_ready = (left == 1); left--;
      end else begin
        mem_req = 1'b0; mem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      ea = exp_outs(1'b1);
      eb = exp_outs(1'b0);
      total++;
      if ({frz_a, iff_a, idf_a, stall_a} !== ea || {frz_b, iff_b, idf_b, stall_b} !== eb) begin
        bad++; $display("FAIL rand_outs n=%0d got_a=%b got_b=%b want_a=%b want_b=%b",
          n, {frz_a, iff_a, idf_a, stall_a}, {frz_b, iff_b, idf_b, stall_b}, ea, eb);
      end
      advance();
      total++;
      if (scnt_a !== sa || fcnt_a !== fa || scnt_b !== sb || fcnt_b !== fb || to_a !== 1'b0 || to_b !== 1'b0) begin
        bad++; $display("FAIL rand_cnt n=%0d got=%0d,%0d,%0d,%0d want=%0d,%0d,%0d,%0d",
          n, scnt_a, fcnt_a, scnt_b, fcnt_b, sa, fa, sb, fb);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    sa = '0; fa = '0; sb = '0; fb = '0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
